imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time instruction memory loader: accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and writes them into the instruction memory through its write-back port (wb_en / wb_address / wb_data). Sits beside the IF stage. Holds the pipeline (PC register, IF/ID register) disabled while a program is being loaded and releases it when loading completes.

## Interface
- BASE_ADDR, 32'h0000_0000, byte address of first written word; must be 4-byte aligned
- DEPTH_WORDS, 256, largest accepted word count (instruction memory capacity)
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low
- start  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERR
- byte_valid  input  1  byte_data is valid
- byte_data  input  8  stream byte
- byte_ready  output  1  loader accepts byte this cycle
- wb_en  output  1  instruction memory write strobe, one cycle per word
- wb_address  output  32  byte address of the word being written
- wb_data  output  32  word being written
- core_en  output  1  enable for PC register and IF/ID register
- busy  output  1  load in progress
- done  output  1  last load completed successfully (level, sticky until next start)
- error  output  1  last load failed (level, sticky until next start)
- words_written  output  32  words written in current/last load

## Operation
- Stream format: 4-byte word count N (little-endian), then N words of 4 bytes each (little-endian), then, when configured, 4-byte checksum.
- A byte transfers on a rising edge where byte_valid && byte_ready.
- States: IDLE → HDR on start. HDR: collect 4 bytes into N; then N == 0 → DONE (or CHK), N > DEPTH_WORDS → ERR, else LOAD. LOAD: collect 4 bytes → WRITE. WRITE: wb_en = 1 for one cycle, words_written++; if words_written reaches N → DONE (or CHK), else → LOAD. CHK: collect 4 bytes, compare → DONE or ERR. DONE/ERR: wait for start → HDR.
- wb_address = BASE_ADDR + 4*i for word i (0-based), 32-bit wrap arithmetic; wb_data = byte0 | byte1<<8 | byte2<<16 | byte3<<24.
- byte_ready = 1 in HDR, LOAD, CHK; 0 in IDLE, WRITE, DONE, ERR.
- core_en = 1 in IDLE and DONE; 0 in HDR, LOAD, WRITE, CHK, ERR.
- busy = 1 in HDR, LOAD, WRITE, CHK.
- start while busy is ignored. start in DONE/ERR clears done, error, words_written, byte counter.
- byte_valid deassertion mid-word stalls; partial word bytes are held.

## Timing
- Reset values: state IDLE, byte_ready 0, wb_en 0, wb_address 0, wb_data 0, core_en 1, busy 0, done 0, error 0, words_written 0.
- Reset assertion mid-load aborts immediately (asynchronous); no partial word is written.
- start sampled at edge k → state HDR and byte_ready = 1 in cycle k+1.
- 4th byte of a word accepted at edge k → wb_en, wb_address, wb_data valid in cycle k+1 (registered); byte_ready = 0 in cycle k+1; byte_ready = 1 again in cycle k+2.
- Peak throughput: one word per 5 cycles.
- After final WRITE (or CHK) edge, done and core_en = 1 in the next cycle.
- wb_address/wb_data hold last written value outside WRITE.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined: CHK state present; checksum = XOR of all N data words (0 when N == 0); mismatch → ERR with error = 1, core_en = 0 (words already written remain in memory).
- Undefined: no CHK state; stream ends after last data word; error only from N > DEPTH_WORDS.

## Structure
- Shared package (rv32i_pkg): loader state encoding, word/byte width constants, header length (4 bytes).
- One sub-module: byte_assembler — 2-bit lane counter plus 32-bit shift register; outputs word and word_complete pulse; clear input driven on start.

## Test plan
- Reset then start, stream N=2, words 32'h0000_0013, 32'h00A0_0093 → wb_en pulses twice, addresses BASE_ADDR and BASE_ADDR+4, done=1, core_en=1, words_written=2.
- Same stream with byte_valid toggled every other cycle → identical writes, no lost or duplicated bytes.
- N = DEPTH_WORDS+1 → ERR after 4th header byte, error=1, core_en=0, no wb_en.
- N=0 → done=1 without any wb_en (CHECKSUM_EN: after checksum 0 accepted).
- Assert rst during second word of N=3 → all outputs at reset values, no further wb_en; start again loads correctly.
- CHECKSUM_EN: N=2 words 32'h1111_1111, 32'h2222_2222 with checksum 32'h3333_3333 → done=1; checksum 32'h0 → error=1.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared definitions for the boot-time instruction memory loader:
// loader state encoding, word/byte widths, header length and small
// per-state output decode helpers.
package rv32i_pkg;

    localparam int WORD_W    = 32;
    localparam int BYTE_W    = 8;
    localparam int HDR_BYTES = 4;

    typedef enum logic [2:0] {
        LD_IDLE  = 3'd0,
        LD_HDR   = 3'd1,
        LD_LOAD  = 3'd2,
        LD_WRITE = 3'd3,
        LD_CHK   = 3'd4,
        LD_DONE  = 3'd5,
        LD_ERR   = 3'd6
    } loader_state_e;

    // Byte address of word idx counted from base, 32-bit wrap arithmetic.
    function automatic logic [WORD_W-1:0] word_addr(input logic [WORD_W-1:0] base,
                                                     input logic [WORD_W-1:0] idx);
        return base + {idx[WORD_W-3:0], 2'b00};
    endfunction

    // The loader takes stream bytes only while collecting header, data or checksum.
    function automatic logic state_ready(input loader_state_e s);
        return (s == LD_HDR) || (s == LD_LOAD) || (s == LD_CHK);
    endfunction

    // The pipeline may run only before any load and after a successful one.
    function automatic logic state_core_en(input loader_state_e s);
        return (s == LD_IDLE) || (s == LD_DONE);
    endfunction

    function automatic logic state_busy(input loader_state_e s);
        return (s == LD_HDR) || (s == LD_LOAD) || (s == LD_WRITE) || (s == LD_CHK);
    endfunction

endpackage

// File: rtl/byte_assembler.sv
// Little-endian word assembler: a 2-bit lane counter and a 32-bit shift
// register. Each accepted byte enters at the top, so after four bytes the
// first one sits in bits [7:0]. word_o/word_complete_o present the word
// in the same cycle the fourth byte is offered.
module byte_assembler
    import rv32i_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              valid_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_complete_o
);

    logic [1:0]        lane_q;
    logic [WORD_W-1:0] shift_q;

    // Word as it will look once the current byte is shifted in.
    always_comb begin
        word_o          = {byte_i, shift_q[WORD_W-1:BYTE_W]};
        word_complete_o = valid_i && (lane_q == 2'd3) && !clear_i;
    end

    // Lane counter and shift register; a partial word is held while valid_i is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q  <= 2'd0;
            shift_q <= {WORD_W{1'b0}};
        end else if (clear_i) begin
            lane_q  <= 2'd0;
            shift_q <= {WORD_W{1'b0}};
        end else if (valid_i) begin
            lane_q  <= lane_q + 2'd1;
            shift_q <= {byte_i, shift_q[WORD_W-1:BYTE_W]};
        end else begin
            lane_q  <= lane_q;
            shift_q <= shift_q;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader. Takes a byte stream (word count N,
// then N little-endian words), writes each word into instruction memory
// through the write-back port and holds the PC / IF-ID registers disabled
// while loading. Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a
// trailing 4-byte XOR checksum that must match for the load to succeed.
module imem_loader
    import rv32i_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        wb_en,
    output logic [31:0] wb_address,
    output logic [31:0] wb_data,
    output logic        core_en,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] words_written
);

    localparam logic [31:0] DEPTH_L = DEPTH_WORDS[31:0];

    loader_state_e state_q, state_d;
    logic [31:0]   n_q, n_d;
    logic [31:0]   words_q, words_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic          wb_en_q, wb_en_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic          ready_q, core_en_q, busy_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]   csum_q, csum_d;
`endif

    logic          start_s;
    logic          accept_s;
    logic [31:0]   word_s;
    logic          word_done_s;

    // start is only honoured outside a load; it also restarts the byte lanes.
    assign start_s  = start && !busy_q;
    assign accept_s = byte_valid && ready_q;

    byte_assembler u_asm (
        .clk             (clk),
        .rst_n           (rst),
        .clear_i         (start_s),
        .valid_i         (accept_s),
        .byte_i          (byte_data),
        .word_o          (word_s),
        .word_complete_o (word_done_s)
    );

    // Next-state, write-port and status flag computation.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        words_d = words_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wb_en_d = 1'b0;
        done_d  = done_q;
        error_d = error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            LD_IDLE, LD_DONE, LD_ERR: begin
                if (start_s) begin
                    state_d = LD_HDR;
                    words_d = 32'd0;
                    done_d  = 1'b0;
                    error_d = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d  = 32'd0;
`endif
                end else begin
                    state_d = state_q;
                end
            end
            LD_HDR: begin
                if (word_done_s) begin
                    n_d = word_s;
                    if (word_s == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = LD_CHK;
`else
                        state_d = LD_DONE;
                        done_d  = 1'b1;
`endif
                    end else if (word_s > DEPTH_L) begin
                        state_d = LD_ERR;
                        error_d = 1'b1;
                    end else begin
                        state_d = LD_LOAD;
                    end
                end else begin
                    state_d = LD_HDR;
                end
            end
            LD_LOAD: begin
                if (word_done_s) begin
                    state_d = LD_WRITE;
                    wb_en_d = 1'b1;
                    addr_d  = word_addr(BASE_ADDR, words_q);
                    data_d  = word_s;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ word_s;
`endif
                end else begin
                    state_d = LD_LOAD;
                end
            end
            LD_WRITE: begin
                words_d = words_q + 32'd1;
                if ((words_q + 32'd1) == n_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = LD_CHK;
`else
                    state_d = LD_DONE;
                    done_d  = 1'b1;
`endif
                end else begin
                    state_d = LD_LOAD;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            LD_CHK: begin
                if (word_done_s) begin
                    if (word_s == csum_q) begin
                        state_d = LD_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = LD_ERR;
                        error_d = 1'b1;
                    end
                end else begin
                    state_d = LD_CHK;
                end
            end
`endif
            default: begin
                state_d = LD_IDLE;
            end
        endcase
    end

    // State and output registers; outputs are decoded from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= LD_IDLE;
            n_q       <= 32'd0;
            words_q   <= 32'd0;
            addr_q    <= 32'd0;
            data_q    <= 32'd0;
            wb_en_q   <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            ready_q   <= 1'b0;
            core_en_q <= 1'b1;
            busy_q    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q    <= 32'd0;
`endif
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            words_q   <= words_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            wb_en_q   <= wb_en_d;
            done_q    <= done_d;
            error_q   <= error_d;
            ready_q   <= state_ready(state_d);
            core_en_q <= state_core_en(state_d);
            busy_q    <= state_busy(state_d);
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    assign byte_ready    = ready_q;
    assign wb_en         = wb_en_q;
    assign wb_address    = addr_q;
    assign wb_data       = data_q;
    assign core_en       = core_en_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign words_written = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: random loads against a reference
// model (expected writes pushed into a scoreboard queue, checked by an
// independent monitor), plus header-limit, empty-load and reset-abort cases.
module tb_imem_loader;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'd0;
    logic        byte_ready, wb_en, core_en, busy, done, error;
    logic [31:0] wb_address, wb_data, words_written;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t sb_q[$];
    int  n_cmp = 0;
    int  n_err = 0;

    imem_loader #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .byte_valid    (byte_valid),
        .byte_data     (byte_data),
        .byte_ready    (byte_ready),
        .wb_en         (wb_en),
        .wb_address    (wb_address),
        .wb_data       (wb_data),
        .core_en       (core_en),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the next expected write.
    always @(negedge clk) begin
        if (wb_en === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", wb_address, wb_data);
            end else begin
                wr_t e;
                e = sb_q.pop_front();
                check("wb_address", wb_address, e.a);
                check("wb_data", wb_data, e.d);
                check("ready_low_in_write", {31'd0, byte_ready}, 32'd0);
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // gap_mode 0: back-to-back, 1: valid low every other cycle, 2: random gaps.
    task automatic send_byte(input logic [7:0] b, input int gap_mode);
        int gap;
        int budget;
        gap = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
        byte_valid = 1'b0;
        for (int g = 0; g < gap; g++) @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        budget = 0;
        while (byte_ready !== 1'b1 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 50) begin
            n_cmp++;
            n_err++;
            $display("FAIL byte_ready_timeout: got 0 expected 1");
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap_mode);
        for (int k = 0; k < 4; k++) send_byte(8'((w >> (8 * k)) & 32'hFF), gap_mode);
    endtask

    task automatic wait_end();
        int budget;
        budget = 0;
        while (done !== 1'b1 && error !== 1'b1 && budget < 40) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 40) begin
            n_cmp++;
            n_err++;
            $display("FAIL completion_timeout: got busy %b expected done or error", busy);
        end
    endtask

    // Full load of the given words; the model is simply "word i lands at BASE+4i".
    task automatic run_load(input logic [31:0] words[$], input int gap_mode, input string tag);
        logic [31:0] csum;
        int          n;
        n = words.size();
        csum = 32'd0;
        for (int i = 0; i < n; i++) begin
            sb_q.push_back('{a: BASE + 32'(4 * i), d: words[i]});
            csum = csum ^ words[i];
        end
        pulse_start();
        send_word(32'(n), gap_mode);
        for (int i = 0; i < n; i++) send_word(words[i], gap_mode);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(csum, gap_mode);
`endif
        wait_end();
        @(negedge clk);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_error"}, {31'd0, error}, 32'd0);
        check({tag, "_core_en"}, {31'd0, core_en}, 32'd1);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_words_written"}, words_written, 32'(n));
        check({tag, "_writes_left"}, 32'(sb_q.size()), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_byte_ready"}, {31'd0, byte_ready}, 32'd0);
        check({tag, "_wb_en"}, {31'd0, wb_en}, 32'd0);
        check({tag, "_wb_address"}, wb_address, 32'd0);
        check({tag, "_wb_data"}, wb_data, 32'd0);
        check({tag, "_core_en"}, {31'd0, core_en}, 32'd1);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_error"}, {31'd0, error}, 32'd0);
        check({tag, "_words_written"}, words_written, 32'd0);
    endtask

    initial begin
        logic [31:0] ws[$];

        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b1;
        @(negedge clk);

        // start sampled at edge k gives HDR with byte_ready in cycle k+1.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_byte_ready", {31'd0, byte_ready}, 32'd1);
        check("start_busy", {31'd0, busy}, 32'd1);
        check("start_core_en", {31'd0, core_en}, 32'd0);
        // Extra start while busy must be ignored; then finish as an empty load.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_word(32'd0, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(32'd0, 0);
`endif
        wait_end();
        @(negedge clk);
        check("empty_done", {31'd0, done}, 32'd1);
        check("empty_words", words_written, 32'd0);

        // Directed two-word program, then the same with valid toggling.
        ws = '{32'h0000_0013, 32'h00A0_0093};
        run_load(ws, 0, "prog");
        run_load(ws, 1, "prog_gap");

        // Word count one above capacity fails right after the header.
        pulse_start();
        send_word(32'(DEPTH + 1), 0);
        repeat (2) @(negedge clk);
        check("ovf_error", {31'd0, error}, 32'd1);
        check("ovf_done", {31'd0, done}, 32'd0);
        check("ovf_core_en", {31'd0, core_en}, 32'd0);
        check("ovf_busy", {31'd0, busy}, 32'd0);
        check("ovf_byte_ready", {31'd0, byte_ready}, 32'd0);

        // Exactly capacity is accepted; address arithmetic reaches the top word.
        ws.delete();
        for (int i = 0; i < DEPTH; i++) ws.push_back($urandom);
        run_load(ws, 0, "full");

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Bad checksum: words still written, load reported as failed.
        sb_q.push_back('{a: BASE, d: 32'h1111_1111});
        sb_q.push_back('{a: BASE + 32'd4, d: 32'h2222_2222});
        pulse_start();
        send_word(32'd2, 0);
        send_word(32'h1111_1111, 0);
        send_word(32'h2222_2222, 0);
        send_word(32'h0000_0000, 0);
        wait_end();
        @(negedge clk);
        check("csum_bad_error", {31'd0, error}, 32'd1);
        check("csum_bad_core_en", {31'd0, core_en}, 32'd0);
        ws = '{32'h1111_1111, 32'h2222_2222};
        run_load(ws, 0, "csum_ok");
`endif

        // Reset in the middle of the second word of a three-word load.
        sb_q.push_back('{a: BASE, d: 32'hDEAD_BEEF});
        pulse_start();
        send_word(32'd3, 0);
        send_word(32'hDEAD_BEEF, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        check("abort_writes_done", 32'(sb_q.size()), 32'd0);
        #3 rst = 1'b0;
        #1 check_reset_values("abort");
        repeat (3) @(negedge clk);
        check("abort_no_write", {31'd0, wb_en}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        ws = '{32'h0000_0013, 32'h00A0_0093, 32'h0010_0073};
        run_load(ws, 2, "after_abort");

        // Random programs with random flow control.
        for (int t = 0; t < 6; t++) begin
            int n;
            ws.delete();
            n = int'($urandom_range(1, DEPTH));
            for (int i = 0; i < n; i++) ws.push_back($urandom);
            run_load(ws, int'($urandom_range(0, 2)), "rand");
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
